dbt1_trigger_window: RTL and testbench



---
 rtl/dbt1_trigger_window_pkg.sv | 23 ++
 rtl/dbt1_sat_counter.sv | 24 ++
 rtl/dbt1_trigger_window.sv | 150 +++++++++++++++
 tb/tb_dbt1_trigger_window.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbt1_trigger_window_pkg.sv
// Shared types and constants for the dbt1 trigger window record gate.
// Timestamp width default exists only with DBT1_TRIGGER_WINDOW_TIMESTAMP_EN.
package dbt1_trigger_window_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RECORDING,
      HOLDOFF
   } state_t;

   localparam logic [15:0] MISSED_MAX = 16'hFFFF;

   localparam int PARALLEL_SAMPLES_DEF  = 8;
   localparam int BITS_PER_SAMPLE_DEF   = 16;
   localparam int SAMPLEINDEX_WIDTH_DEF = 3;
   localparam int LEN_WIDTH_DEF         = 16;
   localparam int HOLDOFF_WIDTH_DEF     = 16;
`ifdef DBT1_TRIGGER_WINDOW_TIMESTAMP_EN
   localparam int TIMESTAMP_WIDTH_DEF   = 64;
`endif

endpackage

// File: rtl/dbt1_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module dbt1_sat_counter #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/dbt1_trigger_window.sv
// Per-channel record gate: fixed-length records from primary triggers.
// Optional timestamp latch: define DBT1_TRIGGER_WINDOW_TIMESTAMP_EN.
module dbt1_trigger_window
   import dbt1_trigger_window_pkg::*;
#(
   parameter int PARALLEL_SAMPLES  = PARALLEL_SAMPLES_DEF,
   parameter int BITS_PER_SAMPLE   = BITS_PER_SAMPLE_DEF,
   parameter int SAMPLEINDEX_WIDTH = SAMPLEINDEX_WIDTH_DEF,
   parameter int LEN_WIDTH         = LEN_WIDTH_DEF,
`ifdef DBT1_TRIGGER_WINDOW_TIMESTAMP_EN
   parameter int TIMESTAMP_WIDTH   = TIMESTAMP_WIDTH_DEF,
`endif
   parameter int HOLDOFF_WIDTH     = HOLDOFF_WIDTH_DEF
) (
   input  logic                                    data_clk_i,
   input  logic                                    data_rst_i,
   input  logic                                    arm_i,
   input  logic                                    disarm_i,
   input  logic [LEN_WIDTH-1:0]                    record_len_i,
   input  logic [HOLDOFF_WIDTH-1:0]                holdoff_i,
   input  logic [PARALLEL_SAMPLES*BITS_PER_SAMPLE-1:0] s_sampledata_i,
   input  logic                                    s_trigger_event_i,
   input  logic [SAMPLEINDEX_WIDTH-1:0]            s_trigger_sampleindex_i,
`ifdef DBT1_TRIGGER_WINDOW_TIMESTAMP_EN
   input  logic [TIMESTAMP_WIDTH-1:0]              s_timestamp_i,
   output logic [TIMESTAMP_WIDTH-1:0]              m_timestamp_o,
`endif
   output logic                                    m_valid_o,
   output logic [PARALLEL_SAMPLES*BITS_PER_SAMPLE-1:0] m_data_o,
   output logic                                    m_first_o,
   output logic                                    m_last_o,
   output logic [SAMPLEINDEX_WIDTH-1:0]            m_trigger_sampleindex_o,
   output logic                                    armed_o,
   output logic [31:0]                             record_count_o,
   output logic [15:0]                             missed_count_o
);

   state_t                   state, state_n;
   logic [LEN_WIDTH-1:0]     rem_q, rem_n;
   logic [HOLDOFF_WIDTH-1:0] hold_q, hold_n;
   logic                     pend_q, pend_n;
   logic                     emit, first, last;
   logic                     missed_inc;

   always_comb begin
      state_n = state;
      rem_n   = rem_q;
      hold_n  = hold_q;
      pend_n  = pend_q;
      emit    = 1'b0;
      first   = 1'b0;
      last    = 1'b0;
      unique case (state)
         IDLE: begin
            if (arm_i && !disarm_i) state_n = ARMED;
         end
         ARMED: begin
            if (disarm_i) begin
               state_n = IDLE;
            end else if (s_trigger_event_i) begin
               emit    = 1'b1;
               first   = 1'b1;
               last    = (record_len_i <= LEN_WIDTH'(1));
               rem_n   = (record_len_i == '0) ? '0
                                              : record_len_i - LEN_WIDTH'(1);
               state_n = RECORDING;
            end
         end
         RECORDING: begin
            emit  = 1'b1;
            last  = (rem_q == LEN_WIDTH'(1));
            rem_n = rem_q - LEN_WIDTH'(1);
            if (disarm_i) pend_n = 1'b1;
         end
         HOLDOFF: begin
            if (disarm_i) begin
               state_n = IDLE;
            end else if (hold_q <= HOLDOFF_WIDTH'(1)) begin
               state_n = ARMED;
            end else begin
               hold_n = hold_q - HOLDOFF_WIDTH'(1);
            end
         end
      endcase
      // A disarm arriving on the last word itself also ends in IDLE
      if (last) begin
         pend_n = 1'b0;
         if (pend_q || disarm_i) begin
            state_n = IDLE;
         end else if (holdoff_i == '0) begin
            state_n = ARMED;
         end else begin
            state_n = HOLDOFF;
            hold_n  = holdoff_i;
         end
      end
   end

   always_ff @(posedge data_clk_i or posedge data_rst_i) begin
      if (data_rst_i) begin
         state                   <= IDLE;
         rem_q                   <= '0;
         hold_q                  <= '0;
         pend_q                  <= 1'b0;
         m_valid_o               <= 1'b0;
         m_data_o                <= '0;
         m_first_o               <= 1'b0;
         m_last_o                <= 1'b0;
         m_trigger_sampleindex_o <= '0;
         record_count_o          <= '0;
      end else begin
         state     <= state_n;
         rem_q     <= rem_n;
         hold_q    <= hold_n;
         pend_q    <= pend_n;
         m_valid_o <= emit;
         m_data_o  <= emit ? s_sampledata_i : '0;
         m_first_o <= first;
         m_last_o  <= last;
         if (first) m_trigger_sampleindex_o <= s_trigger_sampleindex_i;
         if (last) record_count_o <= record_count_o + 32'd1;
      end
   end

`ifdef DBT1_TRIGGER_WINDOW_TIMESTAMP_EN
   always_ff @(posedge data_clk_i or posedge data_rst_i) begin
      if (data_rst_i) begin
         m_timestamp_o <= '0;
      end else if (first) begin
         m_timestamp_o <= s_timestamp_i;
      end
   end
`endif

   assign armed_o    = (state == ARMED);
   assign missed_inc = s_trigger_event_i &&
                       ((state == RECORDING) || (state == HOLDOFF));

   dbt1_sat_counter #(
      .WIDTH (16),
      .MAX   (MISSED_MAX)
   ) u_missed (
      .clk   (data_clk_i),
      .rst   (data_rst_i),
      .clr   (arm_i),
      .inc   (missed_inc),
      .count (missed_count_o)
   );

endmodule

// File: tb/tb_dbt1_trigger_window.sv
// Scoreboard bench for dbt1_trigger_window.
// Define DBT1_TRIGGER_WINDOW_TIMESTAMP_EN to also cover the timestamp.
module tb_dbt1_trigger_window;

   localparam int DW = 128;

   typedef struct {
      logic [DW-1:0] d;
      logic          f;
      logic          l;
      logic [2:0]    idx;
      logic [63:0]   ts;
   } exp_t;

   logic           data_clk_i = 1'b0;
   logic           data_rst_i;
   logic           arm_i;
   logic           disarm_i;
   logic [15:0]    record_len_i;
   logic [15:0]    holdoff_i;
   logic [DW-1:0]  s_sampledata_i;
   logic           s_trigger_event_i;
   logic [2:0]     s_trigger_sampleindex_i;
   logic [63:0]    ts_val;
   logic           m_valid_o;
   logic [DW-1:0]  m_data_o;
   logic           m_first_o;
   logic           m_last_o;
   logic [2:0]     m_trigger_sampleindex_o;
   logic           armed_o;
   logic [31:0]    record_count_o;
   logic [15:0]    missed_count_o;
`ifdef DBT1_TRIGGER_WINDOW_TIMESTAMP_EN
   logic [63:0]    m_timestamp_o;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   exp_t e;
   logic [2:0]  cur_idx;
   logic [63:0] cur_ts;

   always #5 data_clk_i = ~data_clk_i;

   dbt1_trigger_window dut (
      .data_clk_i              (data_clk_i),
      .data_rst_i              (data_rst_i),
      .arm_i                   (arm_i),
      .disarm_i                (disarm_i),
      .record_len_i            (record_len_i),
      .holdoff_i               (holdoff_i),
      .s_sampledata_i          (s_sampledata_i),
      .s_trigger_event_i       (s_trigger_event_i),
      .s_trigger_sampleindex_i (s_trigger_sampleindex_i),
`ifdef DBT1_TRIGGER_WINDOW_TIMESTAMP_EN
      .s_timestamp_i           (ts_val),
      .m_timestamp_o           (m_timestamp_o),
`endif
      .m_valid_o               (m_valid_o),
      .m_data_o                (m_data_o),
      .m_first_o               (m_first_o),
      .m_last_o                (m_last_o),
      .m_trigger_sampleindex_o (m_trigger_sampleindex_o),
      .armed_o                 (armed_o),
      .record_count_o          (record_count_o),
      .missed_count_o          (missed_count_o)
   );

   task automatic check(input string tag,
                        input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge data_clk_i) begin
      if (!data_rst_i) begin
         if (m_valid_o) begin
            if (sb.size() == 0) begin
               check("unexpected_word", 1, 0);
            end else begin
               e = sb.pop_front();
               check("word_data", m_data_o, e.d);
               check("word_first", DW'(m_first_o), DW'(e.f));
               check("word_last", DW'(m_last_o), DW'(e.l));
               check("word_idx", DW'(m_trigger_sampleindex_o), DW'(e.idx));
`ifdef DBT1_TRIGGER_WINDOW_TIMESTAMP_EN
               check("word_ts", DW'(m_timestamp_o), DW'(e.ts));
`endif
            end
         end else if (m_data_o != '0) begin
            check("idle_data", m_data_o, '0);
         end
      end
   end

   task automatic tick();
      @(posedge data_clk_i);
      #1;
   endtask

   // One input word; push marks it as an expected record word
   task automatic drive(input logic trig, input logic [2:0] idx,
                        input bit push, input bit f, input bit l);
      exp_t x;
      s_sampledata_i = {$urandom, $urandom, $urandom, $urandom};
      ts_val = {$urandom, $urandom};
      s_trigger_event_i = trig;
      s_trigger_sampleindex_i = idx;
      if (f) begin
         cur_idx = idx;
         cur_ts  = ts_val;
      end
      if (push) begin
         x.d = s_sampledata_i;
         x.f = f;
         x.l = l;
         x.idx = cur_idx;
         x.ts = cur_ts;
         sb.push_back(x);
      end
      tick();
      s_trigger_event_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 3'($urandom), 0, 0, 0);
   endtask

   task automatic pulse(input bit a, input bit d);
      arm_i = a;
      disarm_i = d;
      idle(1);
      arm_i = 1'b0;
      disarm_i = 1'b0;
   endtask

   task automatic run_record(input logic [15:0] len, input logic [2:0] idx);
      int n;
      n = (len == 0) ? 1 : int'(len);
      record_len_i = len;
      drive(1, idx, 1, 1, n == 1);
      for (int i = 1; i < n; i++)
         drive(0, 3'($urandom), 1, 0, i == n - 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, DW'(m_valid_o), 0);
      check({tag, "_data"}, m_data_o, 0);
      check({tag, "_first"}, DW'(m_first_o), 0);
      check({tag, "_last"}, DW'(m_last_o), 0);
      check({tag, "_idx"}, DW'(m_trigger_sampleindex_o), 0);
      check({tag, "_armed"}, DW'(armed_o), 0);
      check({tag, "_reccnt"}, DW'(record_count_o), 0);
      check({tag, "_missed"}, DW'(missed_count_o), 0);
`ifdef DBT1_TRIGGER_WINDOW_TIMESTAMP_EN
      check({tag, "_ts"}, DW'(m_timestamp_o), 0);
`endif
   endtask

   initial begin
      data_rst_i = 1'b1;
      arm_i = 1'b0;
      disarm_i = 1'b0;
      record_len_i = '0;
      holdoff_i = '0;
      s_sampledata_i = '0;
      s_trigger_event_i = 1'b0;
      s_trigger_sampleindex_i = '0;
      ts_val = '0;
      cur_idx = '0;
      cur_ts = '0;
      repeat (3) @(posedge data_clk_i);
      #1;
      data_rst_i = 1'b0;
      idle(1);
      check_zero_outputs("reset");

      // length 4, sampleindex 5
      pulse(1, 0);
      check("armed_after_arm", DW'(armed_o), 1);
      run_record(16'd4, 3'd5);
      idle(2);
      check("len4_reccnt", DW'(record_count_o), 1);
      check("len4_idx_held", DW'(m_trigger_sampleindex_o), 5);
      check("len4_rearmed", DW'(armed_o), 1);

      // short records back to back
      run_record(16'd0, 3'd2);
      run_record(16'd1, 3'd7);
      idle(2);
      check("short_reccnt", DW'(record_count_o), 3);

      // holdoff 3: triggers at +1,+2 missed, +4 accepted
      pulse(1, 0);
      holdoff_i = 16'd3;
      run_record(16'd2, 3'd1);
      drive(1, 3'd0, 0, 0, 0);
      drive(1, 3'd0, 0, 0, 0);
      drive(0, 3'd0, 0, 0, 0);
      run_record(16'd3, 3'd4);
      idle(2);
      check("holdoff_missed", DW'(missed_count_o), 2);
      check("holdoff_reccnt", DW'(record_count_o), 5);
      holdoff_i = '0;
      idle(3);
      check("holdoff_rearmed", DW'(armed_o), 1);

      // disarm during an 8-word record
      record_len_i = 16'd8;
      drive(1, 3'd3, 1, 1, 0);
      for (int i = 1; i < 8; i++) begin
         disarm_i = (i == 3);
         drive(0, 3'($urandom), 1, 0, i == 7);
         disarm_i = 1'b0;
      end
      idle(2);
      check("disarm_armed", DW'(armed_o), 0);
      check("disarm_reccnt", DW'(record_count_o), 6);
      drive(1, 3'd1, 0, 0, 0);
      drive(1, 3'd2, 0, 0, 0);
      idle(2);
      check("idle_missed", DW'(missed_count_o), 2);
      pulse(1, 1);
      check("armdis_armed", DW'(armed_o), 0);
      check("armdis_missclr", DW'(missed_count_o), 0);
      drive(1, 3'd6, 0, 0, 0);
      idle(2);
      check("armdis_reccnt", DW'(record_count_o), 6);

      // reset at word 2 of 6
      pulse(1, 0);
      record_len_i = 16'd6;
      drive(1, 3'd2, 1, 1, 0);
      drive(0, 3'd0, 1, 0, 0);
      s_sampledata_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge data_clk_i);
      #1;
      data_rst_i = 1'b1;
      #1;
      sb.delete();
      check_zero_outputs("midrst");
      tick();
      tick();
      data_rst_i = 1'b0;
      idle(1);
      check("postrst_armed", DW'(armed_o), 0);
      pulse(1, 0);
      run_record(16'd3, 3'd6);
      idle(2);
      check("postrst_reccnt", DW'(record_count_o), 1);

      // missed-count saturation across a long record and holdoff
      record_len_i = 16'd60000;
      holdoff_i = 16'd20000;
      drive(1, 3'd3, 1, 1, 0);
      for (int i = 1; i <= 70000; i++)
         drive(1, 3'($urandom), i < 60000, 0, i == 59999);
      check("sat_missed", DW'(missed_count_o), 16'hFFFF);
      pulse(0, 1);
      idle(2);
      check("sat_disarmed", DW'(armed_o), 0);
      check("sat_reccnt", DW'(record_count_o), 2);
      check("sat_hold", DW'(missed_count_o), 16'hFFFF);

      check("sb_empty", DW'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
